// File: rtl/cas_key_loader.sv
// Byte-stream key loader with a write-once commit register feeding the CAS-Lock c499 netlist.
// Build option KEY_CRC_EN: the stream carries a trailing CRC-8 byte (poly 0x07), with a bounded retry budget.
module cas_key_loader #(
  parameter int               KEY_W     = 64,
  parameter logic [KEY_W-1:0] DECOY_KEY = '0,
  parameter int               MAX_TRIES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err,
  output logic             lockout
);

  localparam int NBYTES = KEY_W / 8;
  localparam int CNT_W  = $clog2(NBYTES + 1);

  if ((KEY_W % 8) != 0 || KEY_W < 8) begin : g_bad_key_w
    $error("cas_key_loader: KEY_W must be a positive multiple of 8");
  end
  if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
    $error("cas_key_loader: MAX_TRIES must lie in 1..15");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CRC, S_CHECK, S_DONE, S_FAIL, S_LOCK
  } state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic [KEY_W-1:0]   shadow;
  logic               accept, last_byte, enter_load;
  logic               in_ready_d, busy_d, key_valid_d;
  logic [KEY_W-1:0]   key_out_d;

  assign accept     = in_valid & in_ready;
  assign last_byte  = (cnt == CNT_W'(NBYTES - 1));
  assign enter_load = (next_state == S_LOAD) && (state != S_LOAD);

`ifdef KEY_CRC_EN
  logic [7:0] crc, crc_rx;
  logic [3:0] tries;
  logic       pass, tries_exhausted;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  assign pass            = (crc == crc_rx);
  assign tries_exhausted = (({1'b0, tries} + 5'd1) >= 5'(MAX_TRIES));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_LOAD;
      S_LOAD:  if (accept && last_byte) begin
`ifdef KEY_CRC_EN
                 next_state = S_CRC;
`else
                 next_state = S_CHECK;
`endif
               end
      S_CRC:   if (accept) next_state = S_CHECK;
      S_CHECK: begin
`ifdef KEY_CRC_EN
                 if (pass)                 next_state = S_DONE;
                 else if (tries_exhausted) next_state = S_LOCK;
                 else                      next_state = S_FAIL;
`else
                 next_state = S_DONE;
`endif
               end
      S_FAIL:  if (start) next_state = S_LOAD;
      default: next_state = state;
    endcase
  end

  // The commit happens once, on the first edge spent in DONE, so key_out never shows a partial shadow.
  always_comb begin
    in_ready_d  = (next_state == S_LOAD) || (next_state == S_CRC);
    busy_d      = in_ready_d || (next_state == S_CHECK);
    key_valid_d = key_valid;
    key_out_d   = key_out;
    if (state == S_DONE && !key_valid) begin
      key_valid_d = 1'b1;
      key_out_d   = shadow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      key_out   <= DECOY_KEY;
    end else begin
      in_ready  <= in_ready_d;
      busy      <= busy_d;
      key_valid <= key_valid_d;
      key_out   <= key_out_d;
      if (enter_load)                  cnt <= '0;
      else if (state == S_LOAD && accept) cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enter_load) begin
      shadow <= '0;
    end else if (state == S_LOAD && accept) begin
      for (int k = 0; k < NBYTES; k++)
        if (cnt == CNT_W'(k)) shadow[8*k +: 8] <= in_data;
    end
  end

`ifdef KEY_CRC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc     <= 8'h00;
      crc_rx  <= 8'h00;
      tries   <= 4'd0;
      err     <= 1'b0;
      lockout <= 1'b0;
    end else begin
      if (enter_load)                     crc <= 8'h00;
      else if (state == S_LOAD && accept) crc <= crc8_byte(crc, in_data);
      if (state == S_CRC && accept) crc_rx <= in_data;
      if (state == S_CHECK && !pass && tries < 4'(MAX_TRIES)) tries <= tries + 4'd1;
      if (enter_load)                     err <= 1'b0;
      else if (state == S_CHECK && !pass) err <= 1'b1;
      lockout <= (next_state == S_LOCK);
    end
  end
`else
  assign err     = 1'b0;
  assign lockout = 1'b0;
`endif

endmodule

// File: tb/tb_cas_key_loader.sv
// Directed self-checking bench for cas_key_loader; committed keys are scoreboarded through a queue.
module tb_cas_key_loader;

  localparam int               KEY_W = 64;
  localparam logic [KEY_W-1:0] DECOY = 64'h0;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_valid, busy, err, lockout;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  cas_key_loader #(.KEY_W(KEY_W), .DECOY_KEY(DECOY), .MAX_TRIES(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .key_out(key_out), .key_valid(key_valid), .busy(busy),
    .err(err), .lockout(lockout)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk64({tag, "_key_out"}, key_out, DECOY);
    chk1({tag, "_key_valid"}, key_valid, 1'b0);
    chk1({tag, "_in_ready"}, in_ready, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
    chk1({tag, "_lockout"}, lockout, 1'b0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk1("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Full session: bytes LSB-first, a 3-cycle in_valid gap after byte 3, an ignored start after byte 5.
  task automatic send_stream(input logic [63:0] key, input logic [7:0] crc, input bit expect_commit);
    pulse_start();
    chk1("load_busy", busy, 1'b1);
    for (int k = 0; k < 8; k++) begin
`ifndef KEY_CRC_EN
      if (k == 7 && expect_commit) exp_q.push_back(key);
`endif
      send_byte(key[8*k +: 8]);
      chk64("no_leak", key_out, DECOY);
      if (k == 3) repeat (3) @(negedge clk);
      if (k == 5) pulse_start();
    end
`ifdef KEY_CRC_EN
    if (expect_commit) exp_q.push_back(key);
    send_byte(crc);
`else
    if (crc != 8'h00) in_data = crc;
`endif
  endtask

  task automatic wait_commit(input int exp_lat);
    int n = 0;
    logic [63:0] e;
    while (!key_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk1("commit_seen", key_valid, 1'b1);
    chk64("commit_latency", 64'(n), 64'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    chk64("commit_key", key_out, e);
    chk1("commit_busy", busy, 1'b0);
    chk1("commit_err", err, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");

    // in_valid while idle must not be consumed
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (2) @(negedge clk);
    chk1("idle_in_ready", in_ready, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    in_valid = 1'b0;

`ifdef KEY_CRC_EN
    send_stream(64'h1, 8'h13, 1'b1);
    wait_commit(2);
    chk1("good_lockout", lockout, 1'b0);

    pulse_start();
    @(negedge clk);
    chk64("restart_key", key_out, 64'h1);
    chk1("restart_valid", key_valid, 1'b1);
    chk1("restart_busy", busy, 1'b0);

    apply_reset("rst_after_done");
    send_stream(64'h1, 8'h12, 1'b0);
    repeat (2) @(negedge clk);
    chk1("badcrc_err", err, 1'b1);
    chk1("badcrc_valid", key_valid, 1'b0);
    chk64("badcrc_key", key_out, DECOY);
    chk1("badcrc_lockout", lockout, 1'b0);
    send_stream(64'h1, 8'h13, 1'b1);
    wait_commit(2);

    apply_reset("rst_before_lock");
    for (int s = 0; s < 3; s++) begin
      send_stream(64'h1, 8'h00, 1'b0);
      repeat (2) @(negedge clk);
      chk1("lock_err", err, 1'b1);
      chk1("lock_lockout", lockout, (s == 2));
      chk1("lock_valid", key_valid, 1'b0);
    end
    pulse_start();
    in_valid = 1'b1; in_data = 8'h01;
    repeat (3) @(negedge clk);
    chk1("locked_in_ready", in_ready, 1'b0);
    chk1("locked_busy", busy, 1'b0);
    chk1("locked_valid", key_valid, 1'b0);
    chk64("locked_key", key_out, DECOY);
    chk1("locked_lockout", lockout, 1'b1);
    in_valid = 1'b0;
    apply_reset("rst_from_lock");
`else
    send_stream(64'h0123456789ABCDEF, 8'h00, 1'b1);
    wait_commit(2);

    pulse_start();
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(negedge clk);
    chk1("done_in_ready", in_ready, 1'b0);
    chk1("done_busy", busy, 1'b0);
    chk64("done_key_held", key_out, 64'h0123456789ABCDEF);
    chk1("done_valid_held", key_valid, 1'b1);
    in_valid = 1'b0;
`endif

    // Reset with a partial key in the shadow, then a fresh full load
    apply_reset("rst_from_done");
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      send_byte(8'h11 * 8'(k + 1));
      chk64("partial_no_leak", key_out, DECOY);
    end
    chk1("partial_busy", busy, 1'b1);
    apply_reset("rst_mid_load");
`ifdef KEY_CRC_EN
    send_stream(64'h1, 8'h13, 1'b1);
`else
    send_stream(64'hFEDCBA9876543210, 8'h00, 1'b1);
`endif
    wait_commit(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
